// File: rtl/debouncer.sv
// Push-button debouncer: synchronises the raw level, then commits a new output level once it has
// been stable for STABLE_CYCLES clocks. Define DEBOUNCER_EDGE_PULSE_EN to add press/release pulses.
module debouncer #(
  parameter int STABLE_CYCLES = 8,
  parameter int SYNC_STAGES   = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic inButton,
`ifdef DEBOUNCER_EDGE_PULSE_EN
  output logic outPress,
  output logic outRelease,
`endif
  output logic outButton
);

  localparam int CNT_W = $clog2(STABLE_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STABLE_CYCLES - 1);

  generate
    if (STABLE_CYCLES < 1) begin : g_bad_stable
      $error("debouncer: STABLE_CYCLES must be >= 1");
    end
    if (SYNC_STAGES < 2) begin : g_bad_sync
      $error("debouncer: SYNC_STAGES must be >= 2");
    end
  endgenerate

  logic [SYNC_STAGES-1:0] sync_q, sync_d;
  logic [CNT_W-1:0]       cnt_q, cnt_d;
  logic                   out_q, out_d;
  logic                   s;
  logic                   commit;

  always_comb begin
    sync_d = {sync_q[SYNC_STAGES-2:0], inButton};
    s      = sync_q[SYNC_STAGES-1];
    commit = (s != out_q) && (cnt_q == CNT_MAX);
    cnt_d  = '0;
    out_d  = out_q;
    // Any cycle back at the output level leaves cnt_d at 0, restarting the count.
    if (s != out_q) begin
      if (commit) out_d = s;
      else        cnt_d = cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sync_q <= '0;
      cnt_q  <= '0;
      out_q  <= 1'b0;
    end else begin
      sync_q <= sync_d;
      cnt_q  <= cnt_d;
      out_q  <= out_d;
    end
  end

  assign outButton = out_q;

`ifdef DEBOUNCER_EDGE_PULSE_EN
  logic press_q, press_d;
  logic rel_q, rel_d;

  // Pulses come from the same commit decision, so they land on the edge outButton changes.
  always_comb begin
    press_d = commit & s;
    rel_d   = commit & ~s;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      press_q <= 1'b0;
      rel_q   <= 1'b0;
    end else begin
      press_q <= press_d;
      rel_q   <= rel_d;
    end
  end

  assign outPress   = press_q;
  assign outRelease = rel_q;
`endif

endmodule

// File: tb/tb_debouncer.sv
// Bench for debouncer: directed latency/glitch scenarios, then random bouncing levels and resets,
// all checked every cycle against a window-based reference model.
module tb_debouncer;
  localparam int S  = 8;
  localparam int SY = 2;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic inButton = 1'b0;
  logic outButton;
`ifdef DEBOUNCER_EDGE_PULSE_EN
  logic outPress, outRelease;
`endif

  int checks = 0;
  int errors = 0;

  debouncer #(.STABLE_CYCLES(S), .SYNC_STAGES(SY)) dut (
    .clk(clk),
    .rst(rst),
    .inButton(inButton),
`ifdef DEBOUNCER_EDGE_PULSE_EN
    .outPress(outPress),
    .outRelease(outRelease),
`endif
    .outButton(outButton)
  );

  always #5 clk = ~clk;

  // Reference model: a level commits once the last S synchronised samples since the last
  // reset/commit all differ from the current output.
  bit    sh[SY];
  bit    hist[$];
  bit    m_out = 1'b0;
  bit    m_press, m_rel;
  bit    m_valid = 1'b0;
  bit    lit_en = 1'b0;
  bit    lit_v  = 1'b0;
  string lit_name = "";

  always @(posedge clk) begin
    bit s;
    bit all_diff;
    #1;
    m_press = 1'b0;
    m_rel   = 1'b0;
    if (rst) begin
      for (int i = 0; i < SY; i++) sh[i] = 1'b0;
      m_out = 1'b0;
      hist.delete();
      m_valid = 1'b1;
    end else begin
      s = sh[SY-1];
      for (int i = SY-1; i > 0; i--) sh[i] = sh[i-1];
      sh[0] = inButton;
      hist.push_back(s);
      if (hist.size() > S) void'(hist.pop_front());
      all_diff = (hist.size() == S);
      foreach (hist[i]) if (hist[i] == m_out) all_diff = 1'b0;
      if (all_diff) begin
        m_out   = ~m_out;
        m_press = m_out;
        m_rel   = ~m_out;
        hist.delete();
      end
    end
    if (m_valid) begin
      checks++;
      if (outButton !== m_out) begin
        errors++;
        $display("FAIL model_out t=%0t got=%b exp=%b", $time, outButton, m_out);
      end
`ifdef DEBOUNCER_EDGE_PULSE_EN
      checks++;
      if (outPress !== m_press || outRelease !== m_rel) begin
        errors++;
        $display("FAIL model_pulse t=%0t got press=%b rel=%b exp press=%b rel=%b",
                 $time, outPress, outRelease, m_press, m_rel);
      end
`endif
    end
    if (lit_en) begin
      checks++;
      if (outButton !== lit_v) begin
        errors++;
        $display("FAIL %s t=%0t got=%b exp=%b", lit_name, $time, outButton, lit_v);
      end
      if (m_out !== lit_v) begin
        errors++;
        $display("FAIL %s_model t=%0t got=%b exp=%b", lit_name, $time, m_out, lit_v);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic tick_expect(input string name, input bit v);
    lit_en   = 1'b1;
    lit_v    = v;
    lit_name = name;
    tick();
    lit_en   = 1'b0;
  endtask

  // Drive a new level held from edge 1; check old value at edge S+SY-1 and new at edge S+SY.
  task automatic latency(input string name, input bit v);
    inButton = v;
    repeat (S + SY - 2) tick();
    tick_expect({name, "_before"}, ~v);
    tick_expect({name, "_at"}, v);
  endtask

  initial begin
    // 1: reset and idle
    rst = 1'b1; inButton = 1'b0;
    tick();
    tick_expect("reset", 1'b0);
    rst = 1'b0;
    repeat (20) tick_expect("idle", 1'b0);
    // 2: single-cycle pulse is rejected
    inButton = 1'b1; tick();
    inButton = 1'b0;
    repeat (15) tick_expect("short_pulse", 1'b0);
    // 3: clean press
    latency("press", 1'b1);
    repeat (5) tick_expect("press_hold", 1'b1);
    // 5: 7-cycle low glitch rejected, then clean release
    inButton = 1'b0; repeat (7) tick();
    inButton = 1'b1;
    repeat (12) tick_expect("glitch_low", 1'b1);
    latency("release", 1'b0);
    repeat (3) tick_expect("release_hold", 1'b0);
    // 4: bounce, then held high
    repeat (4) begin
      inButton = 1'b1; repeat (3) tick_expect("bounce", 1'b0);
      inButton = 1'b0; tick_expect("bounce", 1'b0);
    end
    latency("bounce_press", 1'b1);
    repeat (4) tick_expect("bounce_hold", 1'b1);
    // 6: reset mid-count with input high
    inButton = 1'b0; repeat (12) tick();
    inButton = 1'b1; repeat (SY + 5) tick();
    rst = 1'b1;
    tick_expect("mid_reset", 1'b0);
    rst = 1'b0;
    repeat (S + SY - 1) tick_expect("post_reset_wait", 1'b0);
    tick_expect("post_reset_rise", 1'b1);
    // Random bouncing levels with occasional resets
    for (int seg = 0; seg < 300; seg++) begin
      if ($urandom_range(0, 39) == 0) begin
        rst = 1'b1; tick(); rst = 1'b0;
      end
      inButton = 1'(($urandom() & 32'h1));
      repeat ($urandom_range(1, 14)) tick();
    end
    inButton = 1'b0;
    repeat (S + SY + 2) tick();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
